// File: rtl/demux_1_n_reg.sv
// Registered 1-to-N demultiplexer with per-channel valid/ready handshake,
// optional all-or-nothing broadcast and a 16-bit count of accepted words.
module demux_1_n_reg #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                din,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            bcast,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [(2**SEL_W)-1:0]           out_valid,
  input  logic [(2**SEL_W)-1:0]           out_ready,
  output logic [(2**SEL_W)*WIDTH-1:0]     dout,
  output logic [15:0]                     acc_cnt
);

  localparam int N = 2**SEL_W;

  logic [N-1:0]            free;
  logic [N-1:0]            target;
  logic [N-1:0]            load;
  logic [N-1:0]            valid_q;
  logic [N-1:0][WIDTH-1:0] data_q;
  logic                    accept;

  // A channel can take a word if it is empty or being drained this cycle.
  assign free = ~valid_q | out_ready;

  always_comb begin
    target = '0;
    if (bcast) begin
      target = '1;
    end else begin
      target[sel] = 1'b1;
    end
  end

  always_comb begin
    in_ready = free[sel];
    if (bcast) begin
      in_ready = &free;
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = accept ? target : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          data_q[k] <= din;
        end
      end
    end
  end

  // A load wins over a drain so a channel can sustain one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 16'd0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 16'd1;
    end
  end

  assign out_valid = valid_q;
  assign dout      = data_q;

endmodule

// File: tb/tb_demux_1_n_reg.sv
// Scoreboard bench for demux_1_n_reg: per-channel expected-word queues filled
// by the stimulus side and drained by a negedge monitor.
module tb_demux_1_n_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic [1:0]  sel;
  logic        bcast;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] dout;
  logic [15:0] acc_cnt;

  demux_1_n_reg #(.WIDTH(8), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  exp_q [4][$];
  logic [7:0]  last_word [4];
  logic [15:0] exp_cnt;
  int          n_vec;
  int          n_err;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a channel holds a word exactly when its queue is non-empty, its
  // data always shows the last word routed to it, and a drain pops the queue.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, exp_q[k].size() != 0});
      checkOutput($sformatf("dout[%0d]", k), {24'd0, dout[k*8 +: 8]}, {24'd0, last_word[k]});
      if (rst_n && out_valid[k] && out_ready[k] && exp_q[k].size() != 0) begin
        checkOutput($sformatf("drain[%0d]", k), {24'd0, dout[k*8 +: 8]}, {24'd0, exp_q[k].pop_front()});
      end
    end
    checkOutput("acc_cnt", {16'd0, acc_cnt}, {16'd0, exp_cnt});
  end

  // Drive one cycle of inputs, then predict readiness from the reference
  // model and record any accepted word in the target queues.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic b,
                               input logic [7:0] d, input logic [3:0] ordy);
    logic [3:0] fr;
    logic       mready;
    @(posedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    bcast     = b;
    din       = d;
    out_ready = ordy;
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) fr[k] = (exp_q[k].size() == 0) || ordy[k];
    mready = b ? (fr == 4'b1111) : fr[s];
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mready});
    if (v && mready) begin
      for (int k = 0; k < 4; k++) begin
        if (b || (k == int'(s))) begin
          exp_q[k].push_back(d);
          last_word[k] = d;
        end
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  // Assert reset between edges, check the immediate clear, and hold a valid
  // input across a reset edge to show it is not taken.
  task automatic doReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_word[k] = 8'h00;
    end
    exp_cnt = 16'd0;
    checkOutput("rst_out_valid", {28'd0, out_valid}, 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    sel      = 2'd0;
    bcast    = 1'b0;
    din      = 8'hEE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    int guard;
    n_vec     = 0;
    n_err     = 0;
    exp_cnt   = 16'd0;
    for (int k = 0; k < 4; k++) last_word[k] = 8'h00;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = 2'd0;
    bcast     = 1'b0;
    din       = 8'h00;
    out_ready = 4'b0000;
    #12;
    rst_n = 1'b1;

    // basic route to channel 2
    applyStimulus(1'b1, 2'd2, 1'b0, 8'hA5, 4'b1111);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    checkOutput("route_valid", {28'd0, out_valid}, 32'h4);
    checkOutput("route_data", {24'd0, dout[23:16]}, 32'hA5);
    checkOutput("route_cnt", {16'd0, acc_cnt}, 32'd1);

    // backpressure on channel 1, then release with back-to-back refill
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h11, 4'b0000);
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h22, 4'b0000);
    checkOutput("bp_hold", {24'd0, dout[15:8]}, 32'h11);
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h22, 4'b0010);
    applyStimulus(1'b0, 2'd1, 1'b0, 8'h00, 4'b0000);
    checkOutput("bp_refill", {24'd0, dout[15:8]}, 32'h22);
    checkOutput("bp_no_gap", {31'd0, out_valid[1]}, 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // broadcast into empty channels, then a blocked broadcast
    applyStimulus(1'b1, 2'd0, 1'b1, 8'h3C, 4'b0000);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    checkOutput("bc_valid", {28'd0, out_valid}, 32'hF);
    checkOutput("bc_data", dout, 32'h3C3C3C3C);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b0111);
    applyStimulus(1'b1, 2'd0, 1'b1, 8'h5A, 4'b0000);
    checkOutput("bc_blocked", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // full-rate stream into channel 0
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd0, 1'b0, 8'(i), 4'b1111);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    checkOutput("stream_cnt", {16'd0, acc_cnt}, 32'd12);

    // asynchronous reset with channels 0 and 3 occupied
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h44, 4'b0000);
    applyStimulus(1'b1, 2'd3, 1'b0, 8'h99, 4'b0000);
    doReset();
    applyStimulus(1'b1, 2'd3, 1'b0, 8'h7E, 4'b1111);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    checkOutput("post_rst_valid", {28'd0, out_valid}, 32'h8);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(3) != 0), 2'($urandom_range(3)),
                    ($urandom_range(4) == 0), 8'($urandom), 4'($urandom));
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // counter wrap
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      applyStimulus(1'b1, 2'($urandom_range(3)), 1'b0, 8'($urandom), 4'b1111);
      guard++;
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    checkOutput("cnt_ffff", {16'd0, acc_cnt}, 32'h0000FFFF);
    applyStimulus(1'b1, 2'd1, 1'b0, 8'hC3, 4'b1111);
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    checkOutput("cnt_wrap", {16'd0, acc_cnt}, 32'd0);
    checkOutput("wrap_data", {24'd0, dout[15:8]}, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
